// File: rtl/prd_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prd_scan_ctrl
// Purpose  : Round-robin period-measurement scheduler. One shared period
//            datapath is time-multiplexed over NCH edge channels: a channel
//            is selected, armed on its first edge, then measured over a
//            WIN_CYC-cycle window. The maximum edge-to-edge period and the
//            number of periods seen are returned on a valid/ready port.
// Ports    : clk        - system clock (rising edge)
//            rst_n      - asynchronous active-low reset
//            start      - level: keep scanning while high
//            ch_mask    - per-channel enable, sampled when selecting
//            medge      - single-cycle edge pulses, one per channel
//            busy       - high whenever the scheduler is not idle
//            cur_ch     - channel currently selected
//            res_valid  - result available
//            res_ready  - consumer accepts result
//            res_ch     - channel index of result
//            res_prd    - maximum period in clk cycles (0 if none)
//            res_cnt    - number of periods measured
//            res_tmo    - no complete period measured
// Revision : 1.0 - initial release
// ============================================================================
module prd_scan_ctrl #(
   parameter int NCH     = 4,
   parameter int CW      = 32,
   parameter int WIN_CYC = 10_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [NCH-1:0]  ch_mask,
   input  logic [NCH-1:0]  medge,
   output logic            busy,
   output logic [2:0]      cur_ch,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [2:0]      res_ch,
   output logic [CW-1:0]   res_prd,
   output logic [CW-1:0]   res_cnt,
   output logic            res_tmo
);

   localparam int            c_IW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] c_WIN_LAST = CW'(WIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEL  = 3'd1,
      S_ARM  = 3'd2,
      S_MEAS = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_first;     // no channel selected since reset
   logic [CW-1:0]   r_p_cnt;     // cycles since the last edge
   logic [CW-1:0]   r_win_cnt;   // position inside the arm / measurement window
   logic [CW-1:0]   r_prd_max;
   logic [CW-1:0]   r_edge_cnt;

   logic            w_edge;
   logic [2:0]      w_next_ch;
   int              w_base;
   logic [CW-1:0]   w_p_inc;
   logic [CW-1:0]   w_cnt_inc;
   logic [CW-1:0]   w_prd_nxt;
   logic [CW-1:0]   w_cnt_nxt;

   assign busy   = (r_state != S_IDLE);
   assign w_edge = medge[cur_ch[c_IW-1:0]];

   // Next enabled channel strictly after cur_ch, wrapping. Scanning from the
   // far end down lets the nearest candidate win. Before the first selection
   // the search starts just "after" NCH-1 so index 0 is considered first.
   always_comb begin
      w_next_ch = '0;
      w_base    = r_first ? (NCH - 1) : int'(cur_ch);
      for (int k = NCH; k >= 1; k--) begin
         if (ch_mask[c_IW'((w_base + k) % NCH)]) begin
            w_next_ch = 3'((w_base + k) % NCH);
         end
      end
   end

   // Saturating increments; the period sample of an edge is p_cnt+1.
   assign w_p_inc   = (r_p_cnt == '1)    ? r_p_cnt    : r_p_cnt + CW'(1);
   assign w_cnt_inc = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + CW'(1);
   assign w_prd_nxt = (w_edge && (w_p_inc > r_prd_max)) ? w_p_inc : r_prd_max;
   assign w_cnt_nxt = w_edge ? w_cnt_inc : r_edge_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_first    <= 1'b1;
         r_p_cnt    <= '0;
         r_win_cnt  <= '0;
         r_prd_max  <= '0;
         r_edge_cnt <= '0;
         cur_ch     <= '0;
         res_valid  <= 1'b0;
         res_ch     <= '0;
         res_prd    <= '0;
         res_cnt    <= '0;
         res_tmo    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (|ch_mask)) begin
                  r_state <= S_SEL;
               end
            end

            S_SEL: begin
               r_p_cnt    <= '0;
               r_win_cnt  <= '0;
               r_prd_max  <= '0;
               r_edge_cnt <= '0;
               if (|ch_mask) begin
                  cur_ch  <= w_next_ch;
                  r_first <= 1'b0;
                  r_state <= S_ARM;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            // An edge on the last arm cycle still arms the measurement.
            S_ARM: begin
               if (w_edge) begin
                  r_p_cnt   <= '0;
                  r_win_cnt <= '0;
                  r_state   <= S_MEAS;
               end else if (r_win_cnt == c_WIN_LAST) begin
                  res_valid <= 1'b1;
                  res_ch    <= cur_ch;
                  res_prd   <= '0;
                  res_cnt   <= '0;
                  res_tmo   <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_win_cnt <= r_win_cnt + CW'(1);
               end
            end

            // Results use the post-update values so an edge on the final
            // window cycle is included.
            S_MEAS: begin
               r_p_cnt    <= w_edge ? '0 : w_p_inc;
               r_prd_max  <= w_prd_nxt;
               r_edge_cnt <= w_cnt_nxt;
               if (r_win_cnt == c_WIN_LAST) begin
                  res_valid <= 1'b1;
                  res_ch    <= cur_ch;
                  res_prd   <= w_prd_nxt;
                  res_cnt   <= w_cnt_nxt;
                  res_tmo   <= (w_cnt_nxt == '0);
                  r_state   <= S_DONE;
               end else begin
                  r_win_cnt <= r_win_cnt + CW'(1);
               end
            end

            S_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  r_state   <= start ? S_SEL : S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
